// File: rtl/audio_pkg.sv
// Shared types and tone table for the game audio path.
// Source enum order doubles as priority: a lower value plays first.
package audio_pkg;

    typedef enum logic [2:0] {
        SRC_HOLE   = 3'd0,
        SRC_BALL   = 3'd1,
        SRC_BORDER = 3'd2,
        SRC_ENTER  = 3'd3,
        SRC_KEYX   = 3'd4,
        SRC_KEYY   = 3'd5,
        SRC_NONE   = 3'd6
    } audio_source_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } sched_state_t;

    localparam logic [9:0] TONE_HOLE   = 10'h0DD;
    localparam logic [9:0] TONE_BALL   = 10'h117;
    localparam logic [9:0] TONE_BORDER = 10'h18B;
    localparam logic [9:0] TONE_ENTER  = 10'h175;
    localparam logic [9:0] TONE_KEYX   = 10'h14C;
    localparam logic [9:0] TONE_KEYY   = 10'h128;

    function automatic logic [9:0] tone_of(audio_source_t src);
        case (src)
            SRC_HOLE:   return TONE_HOLE;
            SRC_BALL:   return TONE_BALL;
            SRC_BORDER: return TONE_BORDER;
            SRC_ENTER:  return TONE_ENTER;
            SRC_KEYX:   return TONE_KEYX;
            SRC_KEYY:   return TONE_KEYY;
            default:    return 10'h000;
        endcase
    endfunction

endpackage

// File: rtl/audio_priority_pick.sv
// Fixed-priority selector over the pending vector; bit index equals the
// audio_source_t value, so the lowest set bit wins.
module audio_priority_pick
    import audio_pkg::*;
(
    input  logic [5:0] pending,
    output logic       any,
    output logic [2:0] highest
);

    always_comb begin
        highest = 3'(SRC_NONE);
        for (int i = 5; i >= 0; i--) begin
            if (pending[i]) begin
                highest = 3'(i);
            end
        end
    end

    assign any = |pending;

endmodule

// File: rtl/audio_event_scheduler.sv
// Turns one-cycle audio event pulses into timed tone bursts with a silent
// gap, by fixed priority, driving the tone generator prescaler.
module audio_event_scheduler
    import audio_pkg::*;
#(
    parameter int TONE_CYCLES = 2_500_000,
    parameter int GAP_CYCLES  = 500_000
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       holeColAudioRequest,
    input  logic       ballToBallColAudioRequest,
    input  logic       borderColAudioRequest,
    input  logic       keyEnterAudioRequest,
    input  logic       keyXAudioRequest,
    input  logic       keyYAudioRequest,
    output logic [9:0] preScaleValue,
    output logic       enableSound,
    output logic       busy,
    output logic [2:0] currentSource
);

    localparam int MAX_CYCLES = (TONE_CYCLES > GAP_CYCLES) ? TONE_CYCLES : GAP_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TONE_LOAD = CNT_W'(TONE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    sched_state_t   state;
    audio_source_t  curSrc;
    audio_source_t  pickSrc;
    logic [CNT_W-1:0] counter;
    logic [5:0]     pending;
    logic [5:0]     reqVec;
    logic [5:0]     clearMask;
    logic [5:0]     pendingNext;
    logic [2:0]     pickHighest;
    logic           pickAny;
    logic           startTone;

    assign reqVec = {keyYAudioRequest, keyXAudioRequest, keyEnterAudioRequest,
                     borderColAudioRequest, ballToBallColAudioRequest, holeColAudioRequest};

    audio_priority_pick uPick (
        .pending (pending),
        .any     (pickAny),
        .highest (pickHighest)
    );

    assign pickSrc       = audio_source_t'(pickHighest);
    assign currentSource = 3'(curSrc);

    // In PLAY only a strictly higher-priority source (lower enum) may cut in.
    always_comb begin
        startTone = 1'b0;
        case (state)
            ST_IDLE: startTone = pickAny;
            ST_PLAY: startTone = pickAny && (pickSrc < curSrc);
            ST_GAP:  startTone = pickAny && (counter == '0);
            default: startTone = 1'b0;
        endcase
        clearMask = startTone ? (6'b000001 << pickHighest) : 6'b000000;
        // A fresh pulse on the bit being cleared keeps it pending.
        pendingNext = (pending & ~clearMask) | reqVec;
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state         <= ST_IDLE;
            pending       <= '0;
            counter       <= '0;
            curSrc        <= SRC_NONE;
            preScaleValue <= '0;
            enableSound   <= 1'b0;
            busy          <= 1'b0;
        end else begin
            pending <= pendingNext;
            if (startTone) begin
                state         <= ST_PLAY;
                counter       <= TONE_LOAD;
                curSrc        <= pickSrc;
                preScaleValue <= tone_of(pickSrc);
                enableSound   <= 1'b1;
                busy          <= 1'b1;
            end else begin
                case (state)
                    ST_PLAY: begin
                        if (counter == '0) begin
                            state         <= ST_GAP;
                            counter       <= GAP_LOAD;
                            curSrc        <= SRC_NONE;
                            preScaleValue <= '0;
                            enableSound   <= 1'b0;
                        end else begin
                            counter <= counter - CNT_W'(1);
                        end
                        busy <= 1'b1;
                    end
                    ST_GAP: begin
                        if (counter == '0) begin
                            state <= ST_IDLE;
                            busy  <= |pendingNext;
                        end else begin
                            counter <= counter - CNT_W'(1);
                            busy    <= 1'b1;
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        counter <= '0;
                        busy    <= |pendingNext;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_audio_event_scheduler.sv
// Directed bench for audio_event_scheduler with TONE_CYCLES=8, GAP_CYCLES=3.
// Outputs are sampled 1 ns after each rising edge; "cycle n" is the n-th sample.
module tb_audio_event_scheduler;

    localparam logic [2:0] S_HOLE   = 3'd0;
    localparam logic [2:0] S_BALL   = 3'd1;
    localparam logic [2:0] S_BORDER = 3'd2;
    localparam logic [2:0] S_ENTER  = 3'd3;
    localparam logic [2:0] S_KEYX   = 3'd4;
    localparam logic [2:0] S_KEYY   = 3'd5;
    localparam logic [2:0] S_NONE   = 3'd6;

    logic       clk = 1'b0;
    logic       resetN;
    logic       holeReq, ballReq, borderReq, enterReq, keyXReq, keyYReq;
    logic [9:0] preScaleValue;
    logic       enableSound;
    logic       busy;
    logic [2:0] currentSource;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    always #5 clk = ~clk;

    audio_event_scheduler #(
        .TONE_CYCLES (8),
        .GAP_CYCLES  (3)
    ) dut (
        .clk                       (clk),
        .resetN                    (resetN),
        .holeColAudioRequest       (holeReq),
        .ballToBallColAudioRequest (ballReq),
        .borderColAudioRequest     (borderReq),
        .keyEnterAudioRequest      (enterReq),
        .keyXAudioRequest          (keyXReq),
        .keyYAudioRequest          (keyYReq),
        .preScaleValue             (preScaleValue),
        .enableSound               (enableSound),
        .busy                      (busy),
        .currentSource             (currentSource)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clearReqs();
        {holeReq, ballReq, borderReq, enterReq, keyXReq, keyYReq} = '0;
    endtask

    task automatic checkOut(input string tag, input logic [9:0] expPre, input logic expEn,
                            input logic expBusy, input logic [2:0] expSrc);
        logic [14:0] got;
        logic [14:0] exp;
        got = {preScaleValue, enableSound, busy, currentSource};
        exp = {expPre, expEn, expBusy, expSrc};
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s cycle %0d: observed pre=%h en=%b busy=%b src=%0d expected pre=%h en=%b busy=%b src=%0d",
                   tag, cyc, preScaleValue, enableSound, busy, currentSource, expPre, expEn, expBusy, expSrc);
        end
    endtask

    // Check n consecutive cycles against the same expected outputs.
    task automatic expectRun(input string tag, input logic [9:0] expPre, input logic expEn,
                             input logic expBusy, input logic [2:0] expSrc, input int n);
        for (int i = 0; i < n; i++) begin
            checkOut(tag, expPre, expEn, expBusy, expSrc);
            step();
        end
    endtask

    initial begin
        resetN = 1'b0;
        clearReqs();

        // 1: reset value, then reset in the middle of an enter tone
        step();
        step();
        checkOut("s1_reset", 10'h000, 1'b0, 1'b0, S_NONE);
        resetN = 1'b1;
        step();
        cyc = 0;
        enterReq = 1'b1;
        checkOut("s1_c0", 10'h000, 1'b0, 1'b0, S_NONE);
        step();
        clearReqs();
        expectRun("s1_pend", 10'h000, 1'b0, 1'b1, S_NONE, 1);
        expectRun("s1_tone", 10'h175, 1'b1, 1'b1, S_ENTER, 2);
        resetN = 1'b0;
        expectRun("s1_tone_last", 10'h175, 1'b1, 1'b1, S_ENTER, 1);
        checkOut("s1_midreset", 10'h000, 1'b0, 1'b0, S_NONE);
        resetN = 1'b1;
        step();
        expectRun("s1_noreplay", 10'h000, 1'b0, 1'b0, S_NONE, 6);

        // 2: single keyX request
        cyc = 0;
        keyXReq = 1'b1;
        checkOut("s2_c0", 10'h000, 1'b0, 1'b0, S_NONE);
        step();
        clearReqs();
        expectRun("s2_pend", 10'h000, 1'b0, 1'b1, S_NONE, 1);
        expectRun("s2_tone", 10'h14C, 1'b1, 1'b1, S_KEYX, 8);
        expectRun("s2_gap", 10'h000, 1'b0, 1'b1, S_NONE, 3);
        expectRun("s2_idle", 10'h000, 1'b0, 1'b0, S_NONE, 2);

        // 3: hole, border and keyY together play in priority order
        cyc = 0;
        holeReq = 1'b1;
        borderReq = 1'b1;
        keyYReq = 1'b1;
        checkOut("s3_c0", 10'h000, 1'b0, 1'b0, S_NONE);
        step();
        clearReqs();
        expectRun("s3_pend", 10'h000, 1'b0, 1'b1, S_NONE, 1);
        expectRun("s3_hole", 10'h0DD, 1'b1, 1'b1, S_HOLE, 8);
        expectRun("s3_gap1", 10'h000, 1'b0, 1'b1, S_NONE, 3);
        expectRun("s3_border", 10'h18B, 1'b1, 1'b1, S_BORDER, 8);
        expectRun("s3_gap2", 10'h000, 1'b0, 1'b1, S_NONE, 3);
        expectRun("s3_keyy", 10'h128, 1'b1, 1'b1, S_KEYY, 8);
        expectRun("s3_gap3", 10'h000, 1'b0, 1'b1, S_NONE, 3);
        expectRun("s3_idle", 10'h000, 1'b0, 1'b0, S_NONE, 2);

        // 4: hole preempts keyY three cycles into the tone
        cyc = 0;
        keyYReq = 1'b1;
        step();
        clearReqs();
        expectRun("s4_pend", 10'h000, 1'b0, 1'b1, S_NONE, 1);
        expectRun("s4_keyy", 10'h128, 1'b1, 1'b1, S_KEYY, 3);
        holeReq = 1'b1;
        expectRun("s4_keyy_k", 10'h128, 1'b1, 1'b1, S_KEYY, 1);
        clearReqs();
        expectRun("s4_keyy_k1", 10'h128, 1'b1, 1'b1, S_KEYY, 1);
        expectRun("s4_hole", 10'h0DD, 1'b1, 1'b1, S_HOLE, 8);
        expectRun("s4_gap", 10'h000, 1'b0, 1'b1, S_NONE, 3);
        expectRun("s4_noreplay", 10'h000, 1'b0, 1'b0, S_NONE, 3);

        // 5: two enter pulses during a border tone merge into one enter tone
        cyc = 0;
        borderReq = 1'b1;
        step();
        clearReqs();
        expectRun("s5_pend", 10'h000, 1'b0, 1'b1, S_NONE, 1);
        expectRun("s5_border_a", 10'h18B, 1'b1, 1'b1, S_BORDER, 2);
        enterReq = 1'b1;
        expectRun("s5_border_b", 10'h18B, 1'b1, 1'b1, S_BORDER, 1);
        clearReqs();
        expectRun("s5_border_c", 10'h18B, 1'b1, 1'b1, S_BORDER, 1);
        enterReq = 1'b1;
        expectRun("s5_border_d", 10'h18B, 1'b1, 1'b1, S_BORDER, 1);
        clearReqs();
        expectRun("s5_border_e", 10'h18B, 1'b1, 1'b1, S_BORDER, 3);
        expectRun("s5_gap1", 10'h000, 1'b0, 1'b1, S_NONE, 3);
        expectRun("s5_enter", 10'h175, 1'b1, 1'b1, S_ENTER, 8);
        expectRun("s5_gap2", 10'h000, 1'b0, 1'b1, S_NONE, 3);
        expectRun("s5_idle", 10'h000, 1'b0, 1'b0, S_NONE, 3);

        // 6: ballToBall re-pulsed on the edge that selects it plays twice
        cyc = 0;
        ballReq = 1'b1;
        step();
        expectRun("s6_pend", 10'h000, 1'b0, 1'b1, S_NONE, 1);
        clearReqs();
        expectRun("s6_tone1", 10'h117, 1'b1, 1'b1, S_BALL, 8);
        expectRun("s6_gap1", 10'h000, 1'b0, 1'b1, S_NONE, 3);
        expectRun("s6_tone2", 10'h117, 1'b1, 1'b1, S_BALL, 8);
        expectRun("s6_gap2", 10'h000, 1'b0, 1'b1, S_NONE, 3);
        expectRun("s6_idle", 10'h000, 1'b0, 1'b0, S_NONE, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/audio_event_scheduler.md
# audio_event_scheduler

Sequences the single-octave tone generator by turning one-cycle game audio events into timed tone bursts. Six event sources can request sound: keys, hole collisions, border collisions and ball-to-ball collisions. The block latches every event, picks one by fixed priority, and drives the prescaler value and sound enable for a fixed tone duration followed by a silent gap. It sits between the game-logic collision/keyboard detectors and the audio prescaler/DAC path.

## Interface
- TONE_CYCLES, 2_500_000: tone length in clocks (100 ms at 25 MHz); legal range ≥ 1.
- GAP_CYCLES, 500_000: silent gap after each tone (20 ms); legal range ≥ 1.
- clk  in  1  system clock, 25 MHz.
- resetN  in  1  synchronous, active-low reset.
- holeColAudioRequest  in  1  pulse: ball entered hole.
- ballToBallColAudioRequest  in  1  pulse: ball-to-ball collision.
- borderColAudioRequest  in  1  pulse: ball hit border.
- keyEnterAudioRequest  in  1  pulse: Enter key rising edge.
- keyXAudioRequest  in  1  pulse: X-axis key (4/6) rising edge.
- keyYAudioRequest  in  1  pulse: Y-axis key (2/8) rising edge.
- preScaleValue  out  10  prescaler value to the tone generator; 0 when silent.
- enableSound  out  1  high while a tone plays.
- busy  out  1  high in PLAY or GAP, or while any request is pending.
- currentSource  out  3  audio_source_t of the tone being played; SRC_NONE otherwise.

## Operation
- Priority, highest first, with prescaler values:
  - hole: 0x0DD (La)
  - ballToBall: 0x117 (fa)
  - border: 0x18B (si)
  - enter: 0x175 (do)
  - keyX: 0x14C (re)
  - keyY: 0x128 (mi)
- Pending register: 6 bits, one per source.
  - A request pulse sets its bit.
  - A bit clears when its source is selected to play.
  - If a set and a clear hit the same bit in the same cycle, the set wins, so the source stays pending.
  - Repeated pulses of a source that is already pending merge into a single pending request.
- FSM states: IDLE, PLAY, GAP.
  - IDLE: if any bit is pending, select the highest-priority one, load the counter with TONE_CYCLES-1, and go to PLAY. Otherwise stay in IDLE.
  - PLAY: enableSound=1 and preScaleValue=tone(currentSource). The counter decrements each cycle. At 0, load GAP_CYCLES-1 and go to GAP.
  - PLAY, preemption: if a pending source has strictly higher priority than currentSource, switch to it on the next edge. The counter reloads with TONE_CYCLES-1 and there is no gap. The preempted tone is dropped and is not re-queued. Pending sources of equal or lower priority wait.
  - GAP: enableSound=0, preScaleValue=0, currentSource=SRC_NONE. At counter 0: if any bit is pending, go directly to PLAY with the highest-priority pending source. Otherwise go to IDLE.
- All outputs are registered; no combinational path from requests to outputs.
- Counter width is $clog2(max(TONE_CYCLES, GAP_CYCLES)), unsigned. It never wraps: it is reloaded on every state entry.

## Timing
- Reset (resetN=0 at an edge), taking effect in one edge from any state including mid-tone:
  - state=IDLE, pending=0, counter=0
  - preScaleValue=0, enableSound=0, busy=0, currentSource=SRC_NONE
- Latency: a request high in cycle 0 sets pending at the end of cycle 0. From IDLE, enableSound and preScaleValue are valid in cycle 2.
- A tone lasts exactly TONE_CYCLES cycles with enableSound high.
- A gap lasts exactly GAP_CYCLES cycles with enableSound low.
- Back-to-back tones are therefore separated by exactly GAP_CYCLES low cycles. There is no IDLE cycle between them.
- Preemption: a higher-priority pulse in cycle k during PLAY gives the new preScaleValue in cycle k+2. enableSound stays high throughout.
- Simultaneous pulses: all are latched; they play in priority order, each followed by a gap.

## Structure
- Package audio_pkg holds:
  - audio_source_t enum: SRC_HOLE, SRC_BALL, SRC_BORDER, SRC_ENTER, SRC_KEYX, SRC_KEYY, SRC_NONE.
  - Localparam tone constants for the six prescaler values.
  - Function tone_of(audio_source_t), returning 10 bits; 0 for SRC_NONE.
- Sub-module audio_priority_pick (combinational):
  - Input: pending[5:0].
  - Outputs: any, highest audio_source_t.
  - Reused for the preemption compare.
- The top level holds the pending register, FSM, counter and output registers.

## Test plan
All scenarios use TONE_CYCLES=8, GAP_CYCLES=3.
1. Reset value and mid-tone reset:
   - Hold resetN=0 → all outputs 0, currentSource=SRC_NONE.
   - Release, pulse keyEnter, assert resetN=0 during the tone → outputs 0 on the next edge, and the enter request is not replayed.
2. Single request:
   - Pulse keyX at cycle 0 → preScaleValue=0x14C and enableSound=1 for cycles 2–9.
   - Silent for cycles 10–12; IDLE at cycle 13; busy falls at cycle 13.
3. Simultaneous requests:
   - Pulse hole, border and keyY in one cycle → order 0x0DD, 0x18B, 0x128.
   - Each tone is 8 cycles, separated by exactly 3 silent cycles.
4. Preemption:
   - Start keyY; pulse hole 3 cycles into the tone → switch to 0x0DD with no gap and a full 8-cycle hole tone.
   - keyY is not replayed.
5. No preemption by lower priority, and merging:
   - During a border tone, pulse keyEnter twice → border completes its 8 cycles, then after the gap exactly one 0x175 tone plays.
6. Set/clear collision:
   - Pulse ballToBall in the same cycle it is selected from pending → two 0x117 tones separated by the gap.
